// File: rtl/div_pkg.sv
// Shared types and constants for the repeated-subtraction divider controller.
package div_pkg;

  localparam int DIV_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    SUB   = 3'd4,
    DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/div_sub_ctrl_quot_counter.sv
// Quotient register: synchronous clear, optional preset to all-ones, increment.
module quot_counter
  import div_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         set,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (set) begin
      q_d = '1;
    end else if (clr) begin
      q_d = '0;
    end else if (inc) begin
      q_d = q_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/div_sub_ctrl.sv
// Sequencer for a divide-by-repeated-subtraction unit driving an external remainder stage.
// Optional build macro DIV_ZERO_DET_EN: short-circuits divisor==0 straight to DONE with a flag.
module div_sub_ctrl
  import div_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  input  logic [W-1:0] rem_in,
  output logic [W-1:0] d_out,
  output logic [W-1:0] din_out,
  output logic         ld,
  output logic         upd,
  output logic [W-1:0] quotient,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero
);

  state_e       state_q, state_d;
  logic [W-1:0] d_q, din_q;
  logic         cap_en;
  logic         q_clr, q_set, q_inc;

  always_comb begin
    state_d = state_q;
    cap_en  = 1'b0;
    q_clr   = 1'b0;
    q_set   = 1'b0;
    q_inc   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          cap_en = 1'b1;
`ifdef DIV_ZERO_DET_EN
          if (divisor == '0) begin
            q_set   = 1'b1;
            state_d = DONE;
          end else begin
            q_clr   = 1'b1;
            state_d = LOAD;
          end
`else
          q_clr   = 1'b1;
          state_d = LOAD;
`endif
        end
      end
      LOAD:  state_d = WAIT;
      WAIT:  state_d = CHECK;
      CHECK: begin
        // Saturated quotient ends the loop even if the remainder still compares high.
        if ((quotient == '1) || (rem_in < d_q)) begin
          state_d = DONE;
        end else begin
          state_d = SUB;
        end
      end
      SUB: begin
        q_inc   = 1'b1;
        state_d = WAIT;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      d_q     <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      if (cap_en) begin
        d_q   <= divisor;
        din_q <= dividend;
      end
    end
  end

`ifdef DIV_ZERO_DET_EN
  logic dz_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      dz_q <= 1'b0;
    end else if (cap_en) begin
      dz_q <= (divisor == '0);
    end
  end

  assign div_by_zero = dz_q && (state_q == DONE);
`else
  assign div_by_zero = 1'b0;
`endif

  quot_counter #(.W(W)) u_quot (
    .clk (clk),
    .rst (rst),
    .clr (q_clr),
    .set (q_set),
    .inc (q_inc),
    .q   (quotient)
  );

  assign d_out   = d_q;
  assign din_out = din_q;
  assign ld      = (state_q == LOAD);
  assign upd     = (state_q == SUB);
  assign done    = (state_q == DONE);
  assign busy    = (state_q == LOAD) || (state_q == WAIT) ||
                   (state_q == CHECK) || (state_q == SUB);

endmodule

// File: tb/tb_div_sub_ctrl.sv
// Directed bench for div_sub_ctrl with a behavioural remainder stage.
module tb_div_sub_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic [7:0] rem_in;
  logic [7:0] d_out, din_out, quotient;
  logic       ld, upd, busy, done, div_by_zero;

  logic [7:0] rem_model = '0;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  div_sub_ctrl #(.W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .rem_in      (rem_in),
    .d_out       (d_out),
    .din_out     (din_out),
    .ld          (ld),
    .upd         (upd),
    .quotient    (quotient),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  // Remainder stage: load on ld, subtract on upd.
  always @(posedge clk) begin
    if (ld) rem_model <= din_out;
    else if (upd) rem_model <= rem_model - d_out;
  end
  assign rem_in = rem_model;

  typedef struct {
    logic [7:0] dd;
    logic [7:0] dv;
    logic [7:0] q;
    logic [7:0] rem;
    int         upds;
    int         lds;
    int         lat;
    logic       dz;
    bit         chk_rem;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic run_div(input logic [7:0] dd, input logic [7:0] dv,
                         output logic [7:0] q, output logic [7:0] r,
                         output int upds, output int lds, output int lat,
                         output logic dz, output bit to, output int both);
    bit fin;
    upds = 0; lds = 0; both = 0; to = 0; fin = 0; q = '0; r = '0; dz = 1'b0;
    @(negedge clk);
    start = 1'b1; dividend = dd; divisor = dv;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    start = 1'b0;
    while (!fin) begin
      if (ld) lds++;
      if (upd) upds++;
      if (ld && upd) both++;
      if (done) begin
        q = quotient; r = rem_in; dz = div_by_zero; fin = 1;
      end else if (lat >= 2000) begin
        to = 1; fin = 1;
      end else begin
        @(posedge clk);
        lat++;
        @(negedge clk);
      end
    end
  endtask

  initial begin
    logic [7:0] q, r;
    int upds, lds, lat, both, cnt_ld, cnt_done, cnt_both;
    logic dz;
    bit to;

    vecs[0] = '{8'd100, 8'd7,   8'd14,  8'd2, 14,  1, 46,  1'b0, 1'b1};
    vecs[1] = '{8'd5,   8'd9,   8'd0,   8'd5, 0,   1, 4,   1'b0, 1'b1};
    vecs[2] = '{8'd255, 8'd1,   8'd255, 8'd0, 255, 1, 769, 1'b0, 1'b1};
    vecs[3] = '{8'd20,  8'd4,   8'd5,   8'd0, 5,   1, 19,  1'b0, 1'b1};
    vecs[4] = '{8'd200, 8'd200, 8'd1,   8'd0, 1,   1, 7,   1'b0, 1'b1};
    vecs[5] = '{8'd0,   8'd5,   8'd0,   8'd0, 0,   1, 4,   1'b0, 1'b1};
`ifdef DIV_ZERO_DET_EN
    vecs[6] = '{8'd13,  8'd0,   8'hFF,  8'd0, 0,   0, 1,   1'b1, 1'b0};
`else
    vecs[6] = '{8'd13,  8'd0,   8'd255, 8'd13, 255, 1, 769, 1'b0, 1'b1};
`endif

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_quotient", quotient, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ld_upd", {ld, upd}, 0);
    chk("rst_dz", div_by_zero, 0);
    chk("rst_dout", {d_out, din_out}, 0);
    // Reset wins over start
    start = 1'b1; dividend = 8'd9; divisor = 8'd3;
    @(negedge clk);
    chk("rst_over_start_ld", ld, 0);
    chk("rst_over_start_busy", busy, 0);
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_no_start_busy", busy, 0);

    for (int i = 0; i < 7; i++) begin
      run_div(vecs[i].dd, vecs[i].dv, q, r, upds, lds, lat, dz, to, both);
      $display("div %0d / %0d -> q=%0d rem=%0d upds=%0d lat=%0d dz=%0d",
               vecs[i].dd, vecs[i].dv, q, r, upds, lat, dz);
      chk("timeout", to, 0);
      chk("quotient", q, vecs[i].q);
      if (vecs[i].chk_rem) chk("remainder", r, vecs[i].rem);
      chk("upd_count", upds, vecs[i].upds);
      chk("ld_count", lds, vecs[i].lds);
      chk("latency", lat, vecs[i].lat);
      chk("div_by_zero", dz, vecs[i].dz);
      chk("ld_upd_overlap", both, 0);
      @(posedge clk); @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("busy_after_done", busy, 0);
      chk("dz_after_done", div_by_zero, 0);
      @(posedge clk); @(negedge clk);
      chk("quotient_hold", quotient, vecs[i].q);
    end

    // Reset during SUB of 100/7
    @(negedge clk);
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    to = 1;
    for (int k = 0; k < 40; k++) begin
      if (upd && quotient == 8'd3) begin
        to = 0;
        break;
      end
      @(posedge clk); @(negedge clk);
    end
    chk("reach_sub", to, 0);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    chk("abort_quotient", quotient, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ld_upd", {ld, upd}, 0);
    cnt_done = 0;
    for (int k = 0; k < 6; k++) begin
      if (done) cnt_done++;
      @(posedge clk); @(negedge clk);
    end
    chk("abort_no_done", cnt_done, 0);
    run_div(8'd20, 8'd4, q, r, upds, lds, lat, dz, to, both);
    $display("after abort: 20 / 4 -> q=%0d rem=%0d lat=%0d", q, r, lat);
    chk("post_abort_timeout", to, 0);
    chk("post_abort_quotient", q, 5);
    chk("post_abort_rem", r, 0);
    chk("post_abort_latency", lat, 19);

    // start held high: 30/6 re-accepted only from IDLE, period 20 cycles
    repeat (3) @(negedge clk);
    start = 1'b1; dividend = 8'd30; divisor = 8'd6;
    cnt_ld = 0; cnt_done = 0; cnt_both = 0;
    for (int k = 0; k < 45; k++) begin
      @(posedge clk); @(negedge clk);
      if (ld) cnt_ld++;
      if (done) cnt_done++;
      if (ld && upd) cnt_both++;
      if (done) chk("held_quotient", quotient, 5);
    end
    start = 1'b0;
    $display("start held 45 cycles: ld=%0d done=%0d", cnt_ld, cnt_done);
    chk("held_ld_count", cnt_ld, 3);
    chk("held_done_count", cnt_done, 2);
    chk("held_overlap", cnt_both, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
